// File: rtl/scroll_frame_drawer_pkg.sv
// Shared constants, FSM encodings and address helpers for the scrolling road frame drawer.
package scroll_frame_drawer_pkg;

   localparam int X_MAX    = 160;
   localparam int Y_MAX    = 120;
   localparam int COLOUR_W = 3;

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_DRAW  = 2'd1;
   localparam logic [1:0] S_FLUSH = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam int SPEED_EIGHTH  = 0;
   localparam int SPEED_QUARTER = 1;
   localparam int SPEED_HALF    = 2;

   // row*160 + col without a multiplier: row*128 + row*32 + col
   function automatic logic [14:0] pixel_addr(input logic [6:0] row, input logic [7:0] col);
      return {1'b0, row, 7'b0} + {3'b0, row, 5'b0} + {7'b0, col};
   endfunction

   function automatic logic [6:0] wrap_row(input logic [6:0] y, input logic [6:0] off);
      logic [7:0] sum;
      sum = {1'b0, y} + (8'(Y_MAX) - {1'b0, off});
      sum = (sum >= 8'(Y_MAX)) ? (sum - 8'(Y_MAX)) : sum;
      return sum[6:0];
   endfunction

endpackage

// File: rtl/scroll_frame_drawer_if.sv
// Background ROM port plus the pixel write bus towards the vga_adapter.
interface scroll_frame_drawer_if;
   import scroll_frame_drawer_pkg::*;

   logic [14:0]         rom_addr;
   logic [COLOUR_W-1:0] rom_data;
   logic [7:0]          VGA_X;
   logic [6:0]          VGA_Y;
   logic [COLOUR_W-1:0] colour;
   logic                plot;

   modport master (output rom_addr, VGA_X, VGA_Y, colour, plot, input rom_data);
   modport slave  (input rom_addr, VGA_X, VGA_Y, colour, plot, output rom_data);
endinterface

// File: rtl/scroll_rate_divider.sv
// Scroll-rate tick generator: one-clock tick every TICK_DIV_BASE x {1,2,4} clocks.
module scroll_rate_divider
   import scroll_frame_drawer_pkg::*;
#(
   parameter int TICK_DIV_BASE = 6_250_000
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   input  logic [2:0] speed_sel,
   output logic       tick
);

   localparam logic [24:0] P_EIGHTH  = 25'(TICK_DIV_BASE);
   localparam logic [24:0] P_QUARTER = 25'(2 * TICK_DIV_BASE);
   localparam logic [24:0] P_HALF    = 25'(4 * TICK_DIV_BASE);

   logic [24:0] count_r;
   logic [24:0] last_s;
   logic [2:0]  speed_prev_r;
   logic        tick_r;

   // terminal count of the selected rate; the fastest set bit wins
   always_comb begin
      last_s = 25'd0;
      if (speed_sel[SPEED_EIGHTH]) begin
         last_s = P_EIGHTH - 25'd1;
      end else if (speed_sel[SPEED_QUARTER]) begin
         last_s = P_QUARTER - 25'd1;
      end else if (speed_sel[SPEED_HALF]) begin
         last_s = P_HALF - 25'd1;
      end else begin
         last_s = 25'd0;
      end
   end

   // counter, rate-change restart and tick register
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         count_r      <= 25'd0;
         speed_prev_r <= 3'b000;
         tick_r       <= 1'b0;
      end else begin
         speed_prev_r <= speed_sel;
         if ((speed_sel != speed_prev_r) || (speed_sel == 3'b000)) begin
            count_r <= 25'd0;
            tick_r  <= 1'b0;
         end else if (count_r == last_s) begin
            count_r <= 25'd0;
            tick_r  <= 1'b1;
         end else begin
            count_r <= count_r + 25'd1;
            tick_r  <= 1'b0;
         end
      end
   end

   assign tick = tick_r;

endmodule

// File: rtl/scroll_frame_drawer.sv
// Redraws the 160x120 road background from a synchronous ROM, one pixel per clock,
// with the source row shifted by a scroll offset that advances once per drawn frame.
module scroll_frame_drawer
   import scroll_frame_drawer_pkg::*;
#(
   parameter int TICK_DIV_BASE = 6_250_000
) (
   input  logic                    CLOCK_50,
   input  logic                    reset,
   input  logic [2:0]              speed_sel,
   scroll_frame_drawer_if.master   bus,
   output logic [6:0]              adjusted_Y,
   output logic [6:0]              offset,
   output logic                    busy,
   output logic                    frame_done
);

   logic        tick_s;
   logic        start_s;
   logic        issue_s;
   logic [6:0]  adj_s;
   logic [6:0]  next_off_s;

   logic [1:0]  state_r;
   logic [7:0]  x_r;
   logic [6:0]  y_r;
   logic        last_r;
   logic        first_r;
   logic        pending_r;
   logic        busy_r;
   logic        frame_done_r;
   logic [6:0]  offset_r;

   logic        av_r;
   logic [6:0]  adj_r;
   logic [14:0] rom_addr_r;
   logic [7:0]  ax_r;
   logic [6:0]  ay_r;
   logic        plot_r;
   logic [7:0]  vga_x_r;
   logic [6:0]  vga_y_r;

   scroll_rate_divider #(
      .TICK_DIV_BASE (TICK_DIV_BASE)
   ) u_div (
      .CLOCK_50  (CLOCK_50),
      .reset     (reset),
      .speed_sel (speed_sel),
      .tick      (tick_s)
   );

   // frame start, address issue qualifier, wrapped source row and next offset
   always_comb begin
      start_s    = (state_r == S_IDLE) && pending_r;
      issue_s    = (state_r == S_DRAW) && !last_r;
      adj_s      = wrap_row(y_r, offset_r);
      next_off_s = first_r ? offset_r
                 : ((offset_r == 7'(Y_MAX - 1)) ? 7'd0 : (offset_r + 7'd1));
   end

   // pending flag and frame sequencing FSM
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state_r      <= S_IDLE;
         x_r          <= 8'd0;
         y_r          <= 7'd0;
         last_r       <= 1'b0;
         first_r      <= 1'b1;
         pending_r    <= 1'b1;
         busy_r       <= 1'b0;
         frame_done_r <= 1'b0;
         offset_r     <= 7'd0;
      end else begin
         if (start_s) begin
            pending_r <= 1'b0;
         end else if (tick_s) begin
            pending_r <= 1'b1;
         end else begin
            pending_r <= pending_r;
         end

         case (state_r)
            S_IDLE: begin
               if (pending_r) begin
                  state_r  <= S_DRAW;
                  x_r      <= 8'd0;
                  y_r      <= 7'd0;
                  last_r   <= 1'b0;
                  busy_r   <= 1'b1;
                  offset_r <= next_off_s;
                  first_r  <= 1'b0;
               end
            end
            S_DRAW: begin
               // last_r marks that rom_addr already holds the final pixel
               if (last_r) begin
                  state_r <= S_FLUSH;
                  last_r  <= 1'b0;
               end else if (x_r == 8'(X_MAX - 1)) begin
                  x_r <= 8'd0;
                  if (y_r == 7'(Y_MAX - 1)) begin
                     last_r <= 1'b1;
                  end else begin
                     y_r <= y_r + 7'd1;
                  end
               end else begin
                  x_r <= x_r + 8'd1;
               end
            end
            S_FLUSH: begin
               state_r      <= S_DONE;
               busy_r       <= 1'b0;
               frame_done_r <= 1'b1;
            end
            S_DONE: begin
               state_r      <= S_IDLE;
               frame_done_r <= 1'b0;
            end
            default: begin
               state_r      <= S_IDLE;
               busy_r       <= 1'b0;
               frame_done_r <= 1'b0;
            end
         endcase
      end
   end

   // address stage then pixel stage, aligned with the one-clock ROM latency
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         av_r       <= 1'b0;
         adj_r      <= 7'd0;
         rom_addr_r <= 15'd0;
         ax_r       <= 8'd0;
         ay_r       <= 7'd0;
         plot_r     <= 1'b0;
         vga_x_r    <= 8'd0;
         vga_y_r    <= 7'd0;
      end else begin
         av_r <= issue_s;
         if (issue_s) begin
            adj_r      <= adj_s;
            rom_addr_r <= pixel_addr(adj_s, x_r);
            ax_r       <= x_r;
            ay_r       <= y_r;
         end
         plot_r <= av_r;
         if (av_r) begin
            vga_x_r <= ax_r;
            vga_y_r <= ay_r;
         end
      end
   end

   assign bus.rom_addr = rom_addr_r;
   assign bus.VGA_X    = vga_x_r;
   assign bus.VGA_Y    = vga_y_r;
   assign bus.plot     = plot_r;
   assign bus.colour   = plot_r ? bus.rom_data : {COLOUR_W{1'b0}};
   assign adjusted_Y   = adj_r;
   assign offset       = offset_r;
   assign busy         = busy_r;
   assign frame_done   = frame_done_r;

endmodule

// File: tb/tb_scroll_frame_drawer.sv
// Directed bench for scroll_frame_drawer with a 1-cycle ROM model (data = addr[2:0]).
module tb_scroll_frame_drawer;
   import scroll_frame_drawer_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic [2:0] speed_sel;
   logic [6:0] adjusted_Y;
   logic [6:0] offset;
   logic       busy;
   logic       frame_done;

   scroll_frame_drawer_if bus ();

   scroll_frame_drawer #(.TICK_DIV_BASE(8)) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .speed_sel  (speed_sel),
      .bus        (bus),
      .adjusted_Y (adjusted_Y),
      .offset     (offset),
      .busy       (busy),
      .frame_done (frame_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) bus.rom_data <= bus.rom_addr[2:0];

   int          checks = 0;
   int          errors = 0;
   int          sb_x, sb_y, frame_plots, first_row, cur_off, lat;
   int          fd_total = 0;
   int          max_adj = 0;
   int          max_addr = 0;
   logic [14:0] prev_addr = 15'd0;
   logic [6:0]  prev_adj = 7'd0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      int row;
      int ea;
      @(negedge clk);
      if (int'(adjusted_Y) > max_adj) max_adj = int'(adjusted_Y);
      if (int'(bus.rom_addr) > max_addr) max_addr = int'(bus.rom_addr);
      if (frame_done === 1'b1) fd_total++;
      if (bus.plot === 1'b1) begin
         row = (sb_y + 120 - cur_off) % 120;
         ea  = row * 160 + sb_x;
         chk("pix_x", 32'(bus.VGA_X), sb_x);
         chk("pix_y", 32'(bus.VGA_Y), sb_y);
         chk("pix_row", 32'(prev_adj), row);
         chk("pix_addr", 32'(prev_addr), ea);
         chk("pix_colour", 32'(bus.colour), ea % 8);
         if (sb_x == 0 && sb_y == 0) first_row = int'(prev_adj);
         frame_plots++;
         sb_x++;
         if (sb_x == 160) begin
            sb_x = 0;
            sb_y++;
         end
      end
      prev_addr = bus.rom_addr;
      prev_adj  = adjusted_Y;
   endtask

   task automatic wait_start(input int exp_off);
      int n;
      n = 0;
      while (busy !== 1'b1 && n < 300) begin
         step();
         n++;
      end
      chk("start_seen", 32'(busy), 32'd1);
      chk("start_offset", 32'(offset), exp_off);
      chk("first_draw_plot", 32'(bus.plot), 32'd0);
      cur_off = exp_off;
      sb_x = 0;
      sb_y = 0;
      frame_plots = 0;
      first_row = -1;
      lat = 1;
   endtask

   task automatic finish_frame();
      while (frame_done !== 1'b1 && lat < 19300) begin
         step();
         lat++;
      end
      chk("latency", lat, 32'd19203);
      chk("plots", frame_plots, 32'd19200);
      chk("busy_in_done", 32'(busy), 32'd0);
      chk("plot_in_done", 32'(bus.plot), 32'd0);
      step();
      chk("done_pulse", 32'(frame_done), 32'd0);
      chk("offset_hold", 32'(offset), cur_off);
   endtask

   initial begin
      int n;
      int early;
      int seen;
      reset = 1'b1;
      speed_sel = 3'b000;
      cur_off = 0;
      sb_x = 0;
      sb_y = 0;
      repeat (3) step();
      chk("rst_plot", 32'(bus.plot), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_offset", 32'(offset), 32'd0);
      chk("rst_done", 32'(frame_done), 32'd0);
      chk("rst_addr", 32'(bus.rom_addr), 32'd0);
      chk("rst_adj", 32'(adjusted_Y), 32'd0);
      chk("rst_vga_x", 32'(bus.VGA_X), 32'd0);
      chk("rst_vga_y", 32'(bus.VGA_Y), 32'd0);
      chk("rst_colour", 32'(bus.colour), 32'd0);

      // paused: exactly one frame at offset 0, then stays idle
      reset = 1'b0;
      wait_start(0);
      finish_frame();
      chk("row_k0", first_row, 32'd0);
      seen = 0;
      repeat (50) begin
         step();
         if (busy === 1'b1) seen++;
      end
      chk("idle_busy", seen, 32'd0);
      chk("frame_done_once", fd_total, 32'd1);

      // eighth-second rate: frames back to back, offset 1 then 2
      speed_sel = 3'b001;
      wait_start(1);
      finish_frame();
      chk("row_k1", first_row, 32'd119);
      wait_start(2);

      // rate divider: 100 then 010 mid-count, then 011
      speed_sel = 3'b100;
      repeat (5) step();
      speed_sel = 3'b010;
      early = 0;
      for (int i = 0; i < 16; i++) begin
         step();
         if (dut.u_div.tick === 1'b1) early++;
      end
      chk("tick_early_010", early, 32'd0);
      step();
      chk("tick_16_after_change", 32'(dut.u_div.tick), 32'd1);
      speed_sel = 3'b011;
      early = 0;
      seen = 0;
      for (int i = 1; i <= 17; i++) begin
         step();
         if (i == 9 || i == 17) begin
            if (dut.u_div.tick === 1'b1) seen++;
         end else if (dut.u_div.tick === 1'b1) begin
            early++;
         end
      end
      chk("tick_011_hits", seen, 32'd2);
      chk("tick_011_stray", early, 32'd0);
      speed_sel = 3'b000;

      // reset mid-frame at pixel (80,60)
      n = 0;
      while (!(bus.plot === 1'b1 && bus.VGA_X == 8'd80 && bus.VGA_Y == 7'd60) && n < 20000) begin
         step();
         n++;
      end
      chk("reach_80_60", 32'(bus.VGA_X) * 32'd256 + 32'(bus.VGA_Y), 32'd80 * 32'd256 + 32'd60);
      reset = 1'b1;
      step();
      chk("abort_plot", 32'(bus.plot), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_offset", 32'(offset), 32'd0);
      chk("abort_addr", 32'(bus.rom_addr), 32'd0);
      reset = 1'b0;
      wait_start(0);
      finish_frame();
      chk("row_redraw", first_row, 32'd0);

      // offset wrap 119 -> 0
      force dut.offset_r = 7'd119;
      step();
      release dut.offset_r;
      step();
      chk("forced_offset", 32'(offset), 32'd119);
      speed_sel = 3'b001;
      wait_start(0);
      repeat (2000) step();
      speed_sel = 3'b000;
      chk("wrap_row0", first_row, 32'd0);
      chk("adj_range", 32'(max_adj <= 119), 32'd1);
      chk("addr_range", 32'(max_addr <= 19199), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
